// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Two-port round-robin arbiter and sequencer for a single-port
//                256x16 memory with combinational read and write on the
//                rising clock edge. Port 0 is instruction fetch and port 1 is
//                the load/store unit. Each granted request owns the memory
//                for exactly one ACCESS cycle. Read data comes back one cycle
//                later through a registered, per-port valid pulse.
//
//  Ports       : clk, reset           - clock and synchronous active-high reset
//                req/we/addr/wdata[01] - request channel of each port
//                gnt0/gnt1             - one-cycle grant pulse (the ACCESS cycle)
//                valid0/valid1         - one-cycle read completion pulse
//                rdata                 - registered read data, shared by ports
//                err                   - one-cycle pulse, write blocked
//                mem_addr/mem_din/mem_wr/mem_dout - memory side
//
//  Build option: MEMARB_WRITE_PROTECT_EN - when defined, writes below
//                WP_LIMIT are granted but not committed, and err pulses.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter logic [7:0] WP_LIMIT = 8'd48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [7:0]  addr0,
    input  logic [7:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        valid0,
    output logic        valid1,
    output logic [15:0] rdata,
    output logic        err,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_wr,
    input  logic [15:0] mem_dout
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_last;       // port granted most recently
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_id;         // port owning the current ACCESS
    logic        r_we;         // captured write enable of the current ACCESS
    logic        r_blk;        // captured write was blocked by protection
    logic [7:0]  r_mem_addr;
    logic [15:0] r_mem_din;
    logic        r_mem_wr;
    logic [15:0] r_rdata;
    logic        r_valid0;
    logic        r_valid1;
    logic        r_err;

    logic        w_m0;
    logic        w_m1;
    logic        w_any;
    logic        w_win;
    logic        w_sel_we;
    logic [7:0]  w_sel_addr;
    logic [15:0] w_sel_wdata;
    logic        w_blk;
    logic        w_in_access;

    // ------------------------------------------------------------------
    // Arbitration and next state
    // ------------------------------------------------------------------
    always_comb begin
        w_in_access = (r_state == S_ACCESS);

        // The port being served right now is masked, so a requester that
        // is still holding req during its grant cycle is not served twice.
        w_m0 = req0 & ~(w_in_access & r_gnt0);
        w_m1 = req1 & ~(w_in_access & r_gnt1);
        w_any = w_m0 | w_m1;

        // Tie goes to the port that was not granted last.
        if (w_m0 && w_m1) begin
            w_win = ~r_last;
        end else begin
            w_win = w_m1;
        end

        w_sel_we    = w_win ? we1    : we0;
        w_sel_addr  = w_win ? addr1  : addr0;
        w_sel_wdata = w_win ? wdata1 : wdata0;

`ifdef MEMARB_WRITE_PROTECT_EN
        w_blk = w_sel_we & (w_sel_addr < WP_LIMIT);
`else
        // Protection absent: never block. The comparison is gated off and
        // only keeps the parameter referenced.
        w_blk = w_sel_we & (w_sel_addr < WP_LIMIT) & 1'b0;
`endif

        w_state_nxt = w_any ? S_ACCESS : S_IDLE;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Capture, ACCESS outputs and completion
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last     <= 1'b1;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_id       <= 1'b0;
            r_we       <= 1'b0;
            r_blk      <= 1'b0;
            r_mem_addr <= 8'd0;
            r_mem_din  <= 16'd0;
            r_mem_wr   <= 1'b0;
            r_rdata    <= 16'd0;
            r_valid0   <= 1'b0;
            r_valid1   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_any) begin
                r_gnt0     <= ~w_win;
                r_gnt1     <= w_win;
                r_id       <= w_win;
                r_we       <= w_sel_we;
                r_blk      <= w_blk;
                r_mem_addr <= w_sel_addr;
                r_mem_din  <= w_sel_wdata;
                r_mem_wr   <= w_sel_we & ~w_blk;
                r_last     <= w_win;
            end else begin
                // Address and data hold their last values while idle.
                r_gnt0     <= 1'b0;
                r_gnt1     <= 1'b0;
                r_mem_wr   <= 1'b0;
            end

            // The edge ending ACCESS completes the access that owned it.
            r_valid0 <= w_in_access & ~r_we & ~r_id;
            r_valid1 <= w_in_access & ~r_we & r_id;
            r_err    <= w_in_access & r_we & r_blk;
            if (w_in_access && !r_we) begin
                r_rdata <= mem_dout;
            end
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign valid0   = r_valid0;
    assign valid1   = r_valid1;
    assign rdata    = r_rdata;
    assign err      = r_err;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_wr   = r_mem_wr;

endmodule
`default_nettype wire
